data_mem_responder: RTL and testbench

Responder end of the MEM-stage data-memory interface: accepts load/store requests driven by the memory-access stage (MemRead, MemWrite, Address, WriteData, DataWidth) and services them from an internal word-organised RAM. Stores complete in one cycle with byte-lane enables. Loads take a parameterised number of wait cycles, during which Stall freezes the pipeline. Load data is lane-extracted and sign- or zero-extended.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   dw_e           DataWidth encodings (word/half/byte/reserved)
//   state_e        load FSM state encoding
//   addr_idx_width word-index width for a given RAM depth
package dmem_pkg;

   typedef enum logic [1:0] {
      DW_WORD = 2'b00,
      DW_HALF = 2'b01,
      DW_BYTE = 2'b10,
      DW_RSVD = 2'b11
   } dw_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   function automatic int unsigned addr_idx_width(input int unsigned depth_words);
      return $clog2(depth_words);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage data-memory bus.
//   master (MEM stage): drives mem_read, mem_write, address, write_data, data_width,
//                       load_unsigned; observes read_data, stall, addr_error.
//   slave (responder):  the mirror image.
interface dmem_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [1:0]  data_width;
   logic        load_unsigned;
   logic [31:0] read_data;
   logic        stall;
   logic        addr_error;

   modport master (
      output mem_read, mem_write, address, write_data, data_width, load_unsigned,
      input  read_data, stall, addr_error
   );

   modport slave (
      input  mem_read, mem_write, address, write_data, data_width, load_unsigned,
      output read_data, stall, addr_error
   );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane logic (little-endian).
//   Store side: i_st_addr_lo/i_st_width/i_st_data -> o_st_be, o_st_data, o_misalign
//               (o_misalign also covers the reserved width).
//   Load side:  i_ld_addr_lo/i_ld_width/i_ld_unsigned/i_ld_word -> o_ld_data
//               (lane extracted, sign- or zero-extended).
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_st_addr_lo,
   input  logic [1:0]  i_st_width,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_data,
   output logic        o_misalign,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [1:0]  i_ld_width,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_ld_shift;

   always_comb begin
      o_st_be    = 4'b0000;
      o_st_data  = i_st_data;
      o_misalign = 1'b0;
      case (dw_e'(i_st_width))
         DW_WORD: begin
            o_st_be    = 4'b1111;
            o_misalign = |i_st_addr_lo;
         end
         DW_HALF: begin
            o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_st_data  = {2{i_st_data[15:0]}};
            o_misalign = i_st_addr_lo[0];
         end
         DW_BYTE: begin
            o_st_be   = 4'b0001 << i_st_addr_lo;
            o_st_data = {4{i_st_data[7:0]}};
         end
         default: o_misalign = 1'b1;
      endcase
   end

   // Shift the addressed lane down to bit 0; a legal half access only shifts by 0 or 16.
   assign w_ld_shift = i_ld_word >> {i_ld_addr_lo, 3'b000};

   always_comb begin
      o_ld_data = i_ld_word;
      case (dw_e'(i_ld_width))
         DW_HALF: o_ld_data = {{16{~i_ld_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
         DW_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_ld_shift[7]}}, w_ld_shift[7:0]};
         default: o_ld_data = i_ld_word;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: services MEM-stage loads/stores from a word-organised RAM.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : request in; read_data (registered), stall and addr_error out.
// Stores write in the request cycle; loads stall READ_LATENCY cycles, then respond.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2
) (
   input logic   i_clk,
   input logic   i_rst_n,
   dmem_if.slave bus
);

   localparam int unsigned AW       = addr_idx_width(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'(READ_LATENCY - 1);

   logic [31:0]   r_mem [DEPTH_WORDS];
   state_e        r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_idx;
   logic [1:0]    r_lo;
   logic [1:0]    r_width;
   logic          r_uns;
   logic [31:0]   r_read_data;

   logic [AW-1:0] w_idx;
   logic          w_idle;
   logic          w_misalign;
   logic          w_illegal;
   logic          w_ld_ok;
   logic          w_st_ok;
   logic [3:0]    w_be;
   logic [31:0]   w_st_data;
   logic [AW-1:0] w_sel_idx;
   logic [1:0]    w_sel_lo;
   logic [1:0]    w_sel_width;
   logic          w_sel_uns;
   logic [31:0]   w_ld_data;
   logic          w_unused_addr;

   // Upper address bits are ignored so accesses wrap over the RAM.
   assign w_idx         = bus.address[AW+1:2];
   assign w_unused_addr = ^bus.address[31:AW+2];

   assign w_idle    = (r_state == StIdle);
   assign w_illegal = w_misalign | (bus.mem_read & bus.mem_write);
   assign w_ld_ok   = w_idle & bus.mem_read & ~w_illegal;
   assign w_st_ok   = w_idle & bus.mem_write & ~w_illegal;

   // Extraction uses the live request in IDLE (single-cycle latency) and the
   // latched copy afterwards.
   assign w_sel_idx   = w_idle ? w_idx : r_idx;
   assign w_sel_lo    = w_idle ? bus.address[1:0] : r_lo;
   assign w_sel_width = w_idle ? bus.data_width : r_width;
   assign w_sel_uns   = w_idle ? bus.load_unsigned : r_uns;

   dmem_lane_align u_lane_align (
      .i_st_addr_lo  (bus.address[1:0]),
      .i_st_width    (bus.data_width),
      .i_st_data     (bus.write_data),
      .o_st_be       (w_be),
      .o_st_data     (w_st_data),
      .o_misalign    (w_misalign),
      .i_ld_addr_lo  (w_sel_lo),
      .i_ld_width    (w_sel_width),
      .i_ld_unsigned (w_sel_uns),
      .i_ld_word     (r_mem[w_sel_idx]),
      .o_ld_data     (w_ld_data)
   );

   // Both flags are forced low while reset is asserted, including mid-load.
   assign bus.stall      = i_rst_n & (w_ld_ok | (r_state == StWait));
   assign bus.addr_error = i_rst_n & w_idle & (bus.mem_read | bus.mem_write) & w_illegal;
   assign bus.read_data  = r_read_data;

   // RAM contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_st_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_lo        <= 2'b00;
         r_width     <= 2'b00;
         r_uns       <= 1'b0;
         r_read_data <= 32'd0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_ld_ok) begin
                  r_idx   <= w_idx;
                  r_lo    <= bus.address[1:0];
                  r_width <= bus.data_width;
                  r_uns   <= bus.load_unsigned;
                  r_cnt   <= CNT_INIT;
                  if (CNT_INIT == 4'd0) begin
                     r_read_data <= w_ld_data;
                     r_state     <= StResp;
                  end else begin
                     r_state <= StWait;
                  end
               end
            end
            StWait: begin
               r_cnt <= r_cnt - 4'd1;
               // Respond when the decremented count reaches zero.
               if (r_cnt == 4'd1) begin
                  r_read_data <= w_ld_data;
                  r_state     <= StResp;
               end
            end
            StResp:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized + directed bench with a byte-array reference model.
module tb_data_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LAT   = 2;
   localparam int unsigned NB    = DEPTH * 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_if bus ();

   data_mem_responder #(
      .DEPTH_WORDS  (DEPTH),
      .READ_LATENCY (LAT)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // Reference model: byte-addressed memory plus the last load result.
   logic [7:0]  m_mem [NB];
   bit          m_known [NB];
   logic [31:0] m_rd;
   bit          m_rd_known;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] w);
      case (w)
         2'b00:   return 4;
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_legal(input bit rd, input bit wr, input logic [31:0] addr,
                                   input logic [1:0] w);
      int n;
      n = nbytes(w);
      if (rd && wr) return 1'b0;
      if (n == 0) return 1'b0;
      return (addr % n) == 0;
   endfunction

   task automatic drive_idle();
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.address       = 32'd0;
      bus.write_data    = 32'd0;
      bus.data_width    = 2'b00;
      bus.load_unsigned = 1'b0;
   endtask

   // One request issued at a falling edge; loads are followed through to RESP.
   task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] w, input bit uns,
                         input string tag);
      int          n;
      int          base;
      int          cyc;
      logic [31:0] v;
      logic [63:0] mask;
      bit          kn;
      @(negedge clk);
      bus.mem_read      = rd;
      bus.mem_write     = wr;
      bus.address       = addr;
      bus.write_data    = wdata;
      bus.data_width    = w;
      bus.load_unsigned = uns;
      #1;
      n    = nbytes(w);
      base = int'(addr % NB);
      if (!(rd || wr)) begin
         check({tag, "_idle_aerr"}, 32'(bus.addr_error), 32'd0);
         check({tag, "_idle_stall"}, 32'(bus.stall), 32'd0);
      end else if (!is_legal(rd, wr, addr, w)) begin
         check({tag, "_aerr"}, 32'(bus.addr_error), 32'd1);
         check({tag, "_err_stall"}, 32'(bus.stall), 32'd0);
         if (m_rd_known) check({tag, "_err_rdata"}, bus.read_data, m_rd);
      end else if (wr) begin
         check({tag, "_st_aerr"}, 32'(bus.addr_error), 32'd0);
         check({tag, "_st_stall"}, 32'(bus.stall), 32'd0);
         for (int i = 0; i < n; i++) begin
            m_mem[(base + i) % NB]   = wdata[8*i +: 8];
            m_known[(base + i) % NB] = 1'b1;
         end
      end else begin
         check({tag, "_ld_stall"}, 32'(bus.stall), 32'd1);
         v  = 32'd0;
         kn = 1'b1;
         for (int i = 0; i < n; i++) begin
            v  = v | (32'(m_mem[(base + i) % NB]) << (8 * i));
            kn = kn & m_known[(base + i) % NB];
         end
         mask = (64'd1 << (8 * n)) - 64'd1;
         if (!uns && n < 4 && v[8*n-1]) v = v | ~mask[31:0];
         cyc = 0;
         do begin
            @(negedge clk);
            #1;
            cyc++;
         end while (bus.stall === 1'b1 && cyc < 20);
         check({tag, "_lat"}, 32'(cyc), 32'(LAT));
         check({tag, "_resp_aerr"}, 32'(bus.addr_error), 32'd0);
         if (kn) check({tag, "_rdata"}, bus.read_data, v);
         m_rd       = v;
         m_rd_known = kn;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          op;
      m_rd       = 32'd0;
      m_rd_known = 1'b1;
      // Reset with a load request present.
      drive_idle();
      bus.mem_read = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_rdata", bus.read_data, 32'd0);
      check("rst_aerr", 32'(bus.addr_error), 32'd0);
      drive_idle();
      rst_n = 1'b1;
      access(1, 0, 32'h0, 0, 2'b00, 0, "lw0_after_rst");

      // Initialise a 64-byte region used by the rest of the bench.
      for (int i = 0; i < 16; i++) access(0, 1, 32'(i * 4), $urandom(), 2'b00, 0, "init");

      access(0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, "sw10");
      access(1, 0, 32'h10, 0, 2'b00, 0, "lw10");
      check("lw10_const", bus.read_data, 32'hDEADBEEF);
      access(0, 1, 32'h11, 32'h80, 2'b10, 0, "sb11");
      access(1, 0, 32'h11, 0, 2'b10, 0, "lb11");
      check("lb11_const", bus.read_data, 32'hFFFFFF80);
      access(1, 0, 32'h11, 0, 2'b10, 1, "lbu11");
      check("lbu11_const", bus.read_data, 32'h00000080);
      access(1, 0, 32'h10, 0, 2'b00, 0, "lw10b");
      check("lw10b_const", bus.read_data, 32'hDEAD80EF);
      access(0, 1, 32'h12, 32'h1234, 2'b01, 0, "sh12");
      access(1, 0, 32'h12, 0, 2'b01, 0, "lh12");
      check("lh12_const", bus.read_data, 32'h00001234);

      access(1, 0, 32'h13, 0, 2'b01, 0, "lh13_err");
      access(0, 1, 32'h12, 32'h55555555, 2'b00, 0, "sw12_err");
      access(1, 0, 32'h10, 0, 2'b00, 0, "lw10_after_err");
      check("lw10_after_err_const", bus.read_data, 32'h123480EF);
      access(1, 1, 32'h10, 32'h0, 2'b00, 0, "rdwr_err");
      access(0, 0, 32'h0, 0, 2'b11, 0, "idle");

      // Reset during the first WAIT cycle.
      @(negedge clk);
      bus.mem_read   = 1'b1;
      bus.address    = 32'h10;
      bus.data_width = 2'b00;
      @(negedge clk);
      #1;
      check("midwait_stall_pre", 32'(bus.stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midwait_stall_rst", 32'(bus.stall), 32'd0);
      check("midwait_rdata_rst", bus.read_data, 32'd0);
      m_rd = 32'd0;
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      access(1, 0, 32'h10, 0, 2'b00, 0, "lw10_reissue");

      access(0, 1, 32'h1000, 32'hCAFEF00D, 2'b00, 0, "sw_wrap");
      access(1, 0, 32'h0, 0, 2'b00, 0, "lw_wrap");
      check("lw_wrap_const", bus.read_data, 32'hCAFEF00D);

      for (int k = 0; k < 300; k++) begin
         op = int'($urandom_range(0, 9));
         a  = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         if (op < 4)       access(0, 1, a, $urandom(), 2'($urandom_range(0, 3)), 0, "rnd_st");
         else if (op < 8)  access(1, 0, a, 0, 2'($urandom_range(0, 3)), 1'($urandom()), "rnd_ld");
         else if (op == 8) access(1, 1, a, $urandom(), 2'($urandom_range(0, 2)), 0, "rnd_rw");
         else              access(0, 0, a, 0, 2'b00, 0, "rnd_idle");
      end

      @(negedge clk);
      drive_idle();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
